// File: rtl/hazard_scoreboard_pkg.sv
// Shared scoreboard entry type and the forwarding legality rule used by the
// hazard unit and the bypass mux.
package hazard_pkg;

    localparam int CNT_MAXW = 8;

    typedef struct packed {
        logic [CNT_MAXW-1:0] cnt;
        logic                late;
    } sb_entry_t;

    // The NZ flags live one entry past the last architectural register.
    function automatic int nz_idx(input int numRegs);
        return numRegs;
    endfunction

    // A late (load) result only becomes forwardable once it reaches writeback.
    function automatic logic fwd_legal(input sb_entry_t e, input logic fwdEn);
        return fwdEn && (e.cnt != '0) && (!e.late || e.cnt == CNT_MAXW'(1));
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard entry: countdown to commit plus the late-result flag.
module sb_entry #(
    parameter int CW       = 2,
    parameter int LOAD_VAL = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          late_i,
    output logic [CW-1:0] cnt_o,
    output logic          late_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          late_q, late_d;

    always_comb begin
        cnt_d  = cnt_q;
        late_d = late_q;
        if (load_i) begin
            cnt_d  = CW'(LOAD_VAL);
            late_d = late_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            late_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            late_q <= late_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign late_o = late_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: decides stall versus forward for the decode-stage
// instruction from per-register and NZ countdown entries.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int REG_AW   = 3,
    parameter int WB_LAT   = 2,
    parameter int FWD_EN   = 1,
    localparam int CW      = $clog2(WB_LAT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              flush,
    input  logic              rd_rx_en,
    input  logic              rd_ry_en,
    input  logic [REG_AW-1:0] src_rx,
    input  logic [REG_AW-1:0] src_ry,
    input  logic              rd_nz,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_reg,
    input  logic              wr_late,
    input  logic              wr_nz,
    output logic              stall,
    output logic              issue_accept,
    output logic              fwd_rx_en,
    output logic [CW-1:0]     fwd_rx_dist,
    output logic              fwd_ry_en,
    output logic [CW-1:0]     fwd_ry_dist,
    output logic [15:0]       stall_count
);

    localparam int NZ_IDX = nz_idx(NUM_REGS);

    logic [CW-1:0]   entryCnt [NUM_REGS+1];
    logic [NZ_IDX:0] entryLate;
    logic [NZ_IDX:0] entryLoad;
    logic [NZ_IDX:0] entryLoadLate;

    genvar g;
    generate
        for (g = 0; g <= NZ_IDX; g++) begin : gen_entry
            sb_entry #(.CW(CW), .LOAD_VAL(WB_LAT)) u_entry (
                .clk    (clk),
                .reset  (reset),
                .load_i (entryLoad[g]),
                .late_i (entryLoadLate[g]),
                .cnt_o  (entryCnt[g]),
                .late_o (entryLate[g])
            );
        end
    endgenerate

    sb_entry_t rxEntry, ryEntry;
    logic      rxHazard, ryHazard, nzHazard;
    logic      fwdEnable;

    assign fwdEnable = (FWD_EN != 0);

    // Out-of-range source indices match no entry and read as committed.
    always_comb begin
        rxEntry = '0;
        ryEntry = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (src_rx == REG_AW'(i)) begin
                rxEntry.cnt  = CNT_MAXW'(entryCnt[i]);
                rxEntry.late = entryLate[i];
            end
            if (src_ry == REG_AW'(i)) begin
                ryEntry.cnt  = CNT_MAXW'(entryCnt[i]);
                ryEntry.late = entryLate[i];
            end
        end
    end

    assign fwd_rx_en   = rd_rx_en && fwd_legal(rxEntry, fwdEnable);
    assign fwd_ry_en   = rd_ry_en && fwd_legal(ryEntry, fwdEnable);
    assign fwd_rx_dist = fwd_rx_en ? rxEntry.cnt[CW-1:0] : '0;
    assign fwd_ry_dist = fwd_ry_en ? ryEntry.cnt[CW-1:0] : '0;

    assign rxHazard = rd_rx_en && (rxEntry.cnt != '0) && !fwd_rx_en;
    assign ryHazard = rd_ry_en && (ryEntry.cnt != '0) && !fwd_ry_en;
    assign nzHazard = rd_nz && (entryCnt[NZ_IDX] != '0) &&
                      !(fwdEnable && entryCnt[NZ_IDX] == CW'(WB_LAT));

    assign stall        = issue_valid && !flush && (rxHazard || ryHazard || nzHazard);
    assign issue_accept = issue_valid && !flush && !stall;

    // A new producer reloads its entry, overriding the pending countdown.
    always_comb begin
        entryLoad     = '0;
        entryLoadLate = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            entryLoad[i]     = issue_accept && wr_en && (wr_reg == REG_AW'(i));
            entryLoadLate[i] = wr_late;
        end
        entryLoad[NZ_IDX] = issue_accept && wr_nz;
    end

    logic [15:0] stallCount_q, stallCount_d;

    always_comb begin
        stallCount_d = stallCount_q;
        if (stall && stallCount_q != 16'hFFFF) begin
            stallCount_d = stallCount_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stallCount_q <= '0;
        end else begin
            stallCount_q <= stallCount_d;
        end
    end

    assign stall_count = stallCount_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard unit for the pipelined CPU. It tracks every register and the NZ flags with per-entry countdown counters.
- It decides stall versus forward for the instruction in decode, and is built to replace the fixed two-stage dependency check.
- It sits between decode and execute. It consumes pre-decoded source/destination fields and drives the PC/decode hold, the issue strobe and the forwarding mux selects.

Parameters:
- NUM_REGS, 8, number of architectural registers; the NZ flags occupy extra entry index NUM_REGS.
- REG_AW, 3, register index width (clog2(NUM_REGS)).
- WB_LAT, 2, cycles from issue (decode to execute) until the result is readable from the register file in decode.
- FWD_EN, 1, 1 = forward when legal; 0 = stall until writeback (legacy behaviour).
- CW, clog2(WB_LAT+1), countdown width (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
- issue_valid  in  1  decode holds a valid instruction that wants to advance.
- flush  in  1  branch taken in execute; kills the instruction in decode this cycle.
- rd_rx_en  in  1  instruction reads Rx.
- rd_ry_en  in  1  instruction reads Ry.
- src_rx  in  REG_AW  Rx index.
- src_ry  in  REG_AW  Ry index.
- rd_nz  in  1  instruction consumes NZ (conditional branch).
- wr_en  in  1  instruction writes a register.
- wr_reg  in  REG_AW  destination index (already resolved Rx/R7).
- wr_late  in  1  result produced late (ld): not forwardable from execute.
- wr_nz  in  1  instruction updates NZ.
- stall  out  1  hold PC and decode.
- issue_accept  out  1  instruction advances into execute this cycle.
- fwd_rx_en  out  1  Rx operand comes from the bypass network.
- fwd_rx_dist  out  CW  pipeline distance of the Rx producer (WB_LAT = execute output, 1 = writeback).
- fwd_ry_en  out  1  Ry operand comes from the bypass network.
- fwd_ry_dist  out  CW  pipeline distance of the Ry producer.
- stall_count  out  16  saturating count of stall cycles since reset.

Behaviour:
- State: cnt[0..NUM_REGS] (CW bits each) and late[0..NUM_REGS]. cnt==0 means the value is committed and readable from the register file in decode this cycle (register file is write-through).
- Reset (reset==0 at a clk edge): all cnt=0, all late=0, stall_count=0. Consequently stall=0, issue_accept=issue_valid&!flush, fwd_*_en=0 and fwd_*_dist=0.
- Per source s in {rx, ry} when enabled:
  - busy = cnt[src]!=0.
  - fwd_ok = FWD_EN & busy & (!late[src] | cnt[src]==1).
  - hazard = busy & !fwd_ok.
- fwd_s_en = enabled & fwd_ok. fwd_s_dist = cnt[src] when fwd_s_en, else 0.
- NZ: hazard_nz = rd_nz & cnt[NUM_REGS]!=0 & !(FWD_EN & cnt[NUM_REGS]==WB_LAT). NZ is never late. NZ is forwarded only from execute output; no NZ distance output exists, because the branch unit reads the live flags.
- stall = issue_valid & !flush & (hazard_rx | hazard_ry | hazard_nz). This is combinational from registered state, with zero-cycle latency.
- issue_accept = issue_valid & !flush & !stall.
- Every clk edge (reset deasserted):
  1. Decrement all nonzero cnt by 1; cnt==0 holds.
  2. Then, if issue_accept & wr_en: cnt[wr_reg]=WB_LAT and late[wr_reg]=wr_late.
  3. If issue_accept & wr_nz: cnt[NUM_REGS]=WB_LAT and late[NUM_REGS]=0.
- Step 2/3 overrides step 1 for the same entry. The younger producer wins (WAW); the older producer's remaining count is discarded.
- An instruction reading and writing the same register checks hazard against the old cnt before the update.
- flush has priority over stall: the killed instruction does not update the scoreboard. Entries of already-issued instructions are unaffected.
- stall_count increments on every cycle with stall==1 and saturates at 16'hFFFF.
- When FWD_EN=0: fwd_*_en is constantly 0 and every busy source stalls until cnt==0.
- Reset asserted mid-stall clears all entries. The next cycle never stalls on pre-reset producers.
- Indices are unsigned. wr_reg/src values ≥ NUM_REGS are illegal; RTL must not index out of range (the entry is ignored).

Decomposition:
- Package hazard_pkg:
  - NZ_IDX = NUM_REGS;
  - typedef sb_entry_t {cnt, late};
  - function fwd_legal(entry, FWD_EN) shared with the bypass mux.
- One sub-module, sb_entry: a single countdown/late register with load, decrement and reset. It is instantiated NUM_REGS+1 times by generate. Hazard and forward logic stays in the top level.

Test Plan:
- add R1 issued, next instruction reads R1 (WB_LAT=2, FWD_EN=1): stall=0, fwd_rx_en=1, fwd_rx_dist=2; the following instruction reading R1 sees dist=1; the one after that sees fwd_rx_en=0.
- ld R3 issued, next instruction reads R3: stall=1 for exactly one cycle, then issue_accept=1 with fwd_rx_dist=1; stall_count=1.
- FWD_EN=0, add R2 then read R2 via Ry: stall=1 for 2 cycles, then issue_accept=1 with fwd_ry_en=0; stall_count=2.
- cmp (wr_nz) issued, next is a conditional branch (rd_nz): no stall with FWD_EN=1; stall 2 cycles with FWD_EN=0.
- WAW: ld R4, then add R4 on the next cycle, then read R4: reader sees late=0 and cnt=2, so forwards with dist=2 and no stall.
- flush=1 with issue_valid=1 on a hazard: stall=0 and issue_accept=0, scoreboard unchanged. Driving reset=0 for one cycle during a stall gives stall=0 and all cnt=0 the next cycle.
